// File: rtl/multiplier_pkg.sv
// Shared constants for the array multiplier.
// Build option: MULTIPLIER_INREG_EN adds an operand register stage, so the
// latency becomes 2 cycles instead of 1.
package multiplier_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_PW     = 2 * DEF_WIDTH;
  localparam int LAT_DIRECT = 1;
  localparam int LAT_INREG  = 2;

`ifdef MULTIPLIER_INREG_EN
  localparam int LATENCY = LAT_INREG;
`else
  localparam int LATENCY = LAT_DIRECT;
`endif

endpackage

// File: rtl/multiplier_fa.sv
// 1-bit full adder cell used to build the ripple rows of the array.
module multiplier_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH product.
// Build option: MULTIPLIER_INREG_EN registers a, b and in_valid ahead of the
// array (latency 2); otherwise the array is fed straight from the ports
// (latency 1). Results are identical in both builds.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_in, b_in;
  logic             vld_in;

`ifdef MULTIPLIER_INREG_EN
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic             vld_in_d, vld_in_q;

  // Next state of the operand stage: always capture the ports.
  always_comb begin
    a_d      = a;
    b_d      = b;
    vld_in_d = in_valid;
  end

  // Operand stage; cleared by reset so nothing stale reaches the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      vld_in_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      vld_in_q <= vld_in_d;
    end
  end

  assign a_in   = a_q;
  assign b_in   = b_q;
  assign vld_in = vld_in_q;
`else
  assign a_in   = a;
  assign b_in   = b;
  assign vld_in = in_valid;
`endif

  // Row i holds the sum of partial products 0..i. It fits in WIDTH+i+1 bits,
  // so each row is sized exactly: bits below i pass through, WIDTH adders
  // add the shifted partial product, and the row carry becomes the top bit.
  logic [PW-1:0] prod;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH+i:0] s;

    if (i == 0) begin : g_first
      assign s = {1'b0, a_in & {WIDTH{b_in[0]}}};
    end else begin : g_add
      logic [WIDTH:0] cy;

      assign cy[0]         = 1'b0;
      assign s[i-1:0]      = g_row[i-1].s[i-1:0];
      assign s[i+WIDTH]    = cy[WIDTH];

      for (genvar k = 0; k < WIDTH; k++) begin : g_fa
        multiplier_fa u_fa (
          .a    (g_row[i-1].s[i+k]),
          .b    (a_in[k] & b_in[i]),
          .cin  (cy[k]),
          .sum  (s[i+k]),
          .cout (cy[k+1])
        );
      end
    end

    if (i == WIDTH - 1) begin : g_last
      assign prod = s;
    end
  end

  logic [PW-1:0] p_d, p_q;
  logic          out_valid_d, out_valid_q;

  // Output stage next state: product tracks the operands every cycle.
  always_comb begin
    p_d         = prod;
    out_valid_d = vld_in;
  end

  // Output registers; reset wins over in_valid and flushes in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier.sv
// Randomized and directed bench for multiplier, checked against a
// delay-line reference model built from plain a*b arithmetic.
module tb_multiplier;
  import multiplier_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int L = LATENCY;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_valid = 1'b0;
  logic [2*W-1:0] p;
  logic           out_valid;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference: expected (product, valid) per output cycle, oldest at L-1
  int mp [L];
  bit mv [L];

  multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .p         (p),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // drive one cycle, advance the model, then check just after the edge
  task automatic tick(input bit r, input int av, input int bv, input bit iv);
    rst      = r;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    in_valid = iv;
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int k = 0; k < L; k++) begin
        mp[k] = 0;
        mv[k] = 1'b0;
      end
    end else begin
      for (int k = L - 1; k > 0; k--) begin
        mp[k] = mp[k-1];
        mv[k] = mv[k-1];
      end
      mp[0] = av * bv;
      mv[0] = iv;
    end
    #1;
    chk("p", 32'(p), 32'(mp[L-1]));
    chk("out_valid", 32'(out_valid), 32'(mv[L-1]));
  endtask

  // hold a pair for one cycle, then let it drain with in_valid low
  task automatic pair2(input int av, input int bv);
    tick(1'b0, av, bv, 1'b1);
    tick(1'b0, av, bv, 1'b0);
  endtask

  initial begin
    int dir_a [5] = '{2, 3, 4, 5, 6};
    int dir_b [5] = '{1, 2, 4, 2, 1};
    int max_v;
    max_v = (1 << W) - 1;

    // reset for two cycles
    tick(1'b1, 3, 5, 1'b1);
    tick(1'b1, 3, 5, 1'b1);
    chk("reset_p_zero", 32'(p), 32'd0);

    // first product 1*1
    tick(1'b0, 1, 1, 1'b1);
    for (int k = 0; k < L; k++) tick(1'b0, 0, 0, 1'b0);

    // directed vectors, two cycles each
    for (int i = 0; i < 5; i++) pair2(dir_a[i], dir_b[i]);

    // corners
    pair2(0, max_v);
    pair2(max_v, 0);
    pair2(max_v, max_v);
    pair2(max_v, 1);
    chk("max_sq_const", 32'(max_v * max_v), 32'd49);

    // streaming, in_valid high every cycle
    for (int i = 0; i < 20; i++)
      tick(1'b0, int'($urandom_range(max_v)), int'($urandom_range(max_v)), 1'b1);

    // reset for one cycle with results in flight
    tick(1'b0, 5, 6, 1'b1);
    tick(1'b0, 7, 3, 1'b1);
    tick(1'b1, 6, 6, 1'b1);
    chk("midreset_p", 32'(p), 32'd0);
    chk("midreset_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 2, 3, 1'(i == 1));

    // exhaustive sweep, streamed
    for (int i = 0; i <= max_v; i++)
      for (int j = 0; j <= max_v; j++)
        tick(1'b0, i, j, 1'b1);

    // random traffic with random valid and occasional reset
    for (int i = 0; i < 200; i++)
      tick(1'($urandom_range(15) == 0), int'($urandom_range(max_v)),
           int'($urandom_range(max_v)), 1'($urandom_range(1)));

    for (int k = 0; k < L; k++) tick(1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
